// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte producers and the uart_tx arbiter.
//   req/req_data    : level requests and their bytes (requester i at [i*DBIT +: DBIT])
//   grant/done      : one-hot 1-cycle pulses back to the requesters
//   timeout_err     : 1-cycle pulse when a frame is aborted by the watchdog
//   tx_start/tx_din : towards uart_tx
//   tx_done_tick    : from uart_tx
//   busy            : arbiter is not idle
// master = producer/uart side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      done;
    logic                 timeout_err;
    logic                 tx_start;
    logic [DBIT-1:0]      tx_din;
    logic                 tx_done_tick;
    logic                 busy;

    modport master (
        output req, req_data, tx_done_tick,
        input  grant, done, timeout_err, tx_start, tx_din, busy
    );

    modport slave (
        input  req, req_data, tx_done_tick,
        output grant, done, timeout_err, tx_start, tx_din, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer in front of a single uart_tx.
// Grants one requester at a time, latches its byte onto tx_din, pulses
// tx_start and waits for tx_done_tick. A watchdog aborts a frame whose
// tx_done_tick never arrives.
// Ports:
//   clk   : system clock, posedge
//   reset : synchronous, active-low
//   bus   : uart_tx_arbiter_if.slave (requests, grants, uart_tx handshake)
// All outputs are registered.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DBIT        = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [DBIT-1:0] tx_din_q, tx_din_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   next_ptr;

    // First set request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!pick_vld && bus.req[(int'(rr_ptr_q) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    // Pointer moves past the owner whether the frame completed or was aborted,
    // so a stuck requester cannot starve the others.
    assign next_ptr = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        tx_din_d   = tx_din_q;
        wdog_d     = wdog_q;
        grant_d    = '0;
        done_d     = '0;
        timeout_d  = 1'b0;
        tx_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d  = pick_idx;
                    tx_din_d = bus.req_data[int'(pick_idx)*DBIT +: DBIT];
                    grant_d  = NREQ'(1) << pick_idx;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_d = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WW'(1);
                // done has priority over a coinciding timeout
                if (bus.tx_done_tick) begin
                    done_d   = NREQ'(1) << owner_q;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            tx_din_q   <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            tx_din_q   <= tx_din_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_din      = tx_din_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; tx_done_tick comes from a stub driven
// by the stimulus sequence. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_uart_tx_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   lat;

    uart_tx_arbiter_if #(.NREQ(4), .DBIT(8)) bus ();

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT_CYC(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, check it, apply the requester's new req
    // vector, then run the frame through LAUNCH/WAIT and finish it with a tick.
    task automatic serve(input int idx, input logic [7:0] byt, input logic [3:0] nreq,
                         output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.grant == 4'b0 && n < 10);
        chk("grant", 32'(bus.grant), 32'(4'b1 << idx));
        chk("grant_din", 32'(bus.tx_din), 32'(byt));
        bus.req = nreq;
        step();
        chk("tx_start", 32'(bus.tx_start), 32'd1);
        chk("grant_pulse", 32'(bus.grant), 32'd0);
        step();
        step();
        chk("busy_wait", 32'(bus.busy), 32'd1);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("done", 32'(bus.done), 32'(4'b1 << idx));
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("din_hold", 32'(bus.tx_din), 32'(byt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.req = 4'b0;
        bus.req_data = '0;
        bus.tx_done_tick = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_din", 32'(bus.tx_din), 32'd0);
        chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
        reset = 1'b1;
        step();

        // single requester
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h55;
        serve(0, 8'h55, 4'b0000, lat);
        chk("single_lat", 32'(lat), 32'd1);
        step();
        chk("done_pulse", 32'(bus.done), 32'd0);

        // contention from rr_ptr=0: order 0,1,2,3,0
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req = 4'b1111;
        serve(0, 8'hA0, 4'b1111, lat);
        serve(1, 8'hA1, 4'b1111, lat);
        chk("b2b_lat", 32'(lat), 32'd1);
        serve(2, 8'hA2, 4'b1111, lat);
        serve(3, 8'hA3, 4'b1111, lat);
        serve(0, 8'hA0, 4'b0000, lat);

        // fairness: serve 1 to move rr_ptr to 2, then req=0101 -> 2 before 0
        bus.req_data = {8'h00, 8'hC2, 8'h11, 8'hC0};
        bus.req = 4'b0010;
        serve(1, 8'h11, 4'b0000, lat);
        bus.req = 4'b0101;
        serve(2, 8'hC2, 4'b0001, lat);
        serve(0, 8'hC0, 4'b0000, lat);

        // spurious ticks in IDLE and LAUNCH are ignored
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("spur_idle_done", 32'(bus.done), 32'd0);
        chk("spur_idle_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h77;
        step();
        chk("spur_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("spur_launch_start", 32'(bus.tx_start), 32'd1);
        chk("spur_launch_done", 32'(bus.done), 32'd0);
        step();
        step();
        chk("spur_wait_done", 32'(bus.done), 32'd0);
        chk("spur_wait_busy", 32'(bus.busy), 32'd1);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("spur_real_done", 32'(bus.done), 32'h1);

        // timeout: rr_ptr=1 so req=0100 picks 2; abort on WAIT cycle 50
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'h99;
        step();
        chk("tmo_grant", 32'(bus.grant), 32'h4);
        bus.req = 4'b0000;
        step();
        chk("tmo_start", 32'(bus.tx_start), 32'd1);
        repeat (49) step();
        chk("tmo_early", 32'(bus.timeout_err), 32'd0);
        chk("tmo_early_busy", 32'(bus.busy), 32'd1);
        step();
        chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        chk("tmo_nodone", 32'(bus.done), 32'd0);
        step();
        chk("tmo_clear", 32'(bus.timeout_err), 32'd0);

        // reset mid-frame (rr_ptr=3 -> picks 0)
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h3C;
        step();
        chk("mid_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_start", 32'(bus.tx_start), 32'd0);
        chk("mid_din", 32'(bus.tx_din), 32'd0);
        bus.tx_done_tick = 1'b1;
        step();
        bus.tx_done_tick = 1'b0;
        chk("mid_nodone", 32'(bus.done), 32'd0);
        // rr_ptr must be back at 0: req=1010 picks 1, not 3
        bus.req_data = {8'hA5, 8'h00, 8'h5A, 8'h00};
        bus.req = 4'b1010;
        serve(1, 8'h5A, 4'b1000, lat);
        serve(3, 8'hA5, 4'b0000, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
